alu_share_arbiter: RTL and testbench

//  Shares one ALU datapath among NUM_REQ requesters using round-robin arbitration.

---
 rtl/alu_share_arbiter.sv | 166 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one ALU among NUM_REQ requesters.
// Registers the winner's operands onto the ALU and returns the result on a tagged response channel.
module alu_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned ALU_LAT = 1,
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [OP_W-1:0]           alu_op,
    input  logic [DATA_W-1:0]         alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_zero,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

    localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;

    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   sel_a, sel_b;
    logic [OP_W-1:0]     sel_op;
    int unsigned         idx;

    // Search starts one past the last grant and wraps, so every pending requester is reached.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(last_grant_q) + off) % NUM_REQ;
            if (!grant_found && req_valid[ID_W'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                sel_a  = req_a[i*DATA_W +: DATA_W];
                sel_b  = req_b[i*DATA_W +: DATA_W];
                sel_op = req_op[i*OP_W +: OP_W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found && !rst)
            req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_id_d     = rsp_id_q;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    alu_a_d      = sel_a;
                    alu_b_d      = sel_b;
                    alu_op_d     = sel_op;
                    last_grant_d = grant_idx;
                    id_d         = grant_idx;
                    cnt_d        = CNT_W'(ALU_LAT - 1);
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_result_d = alu_result;
                    rsp_zero_d   = (alu_result == '0);
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one ALU_LAT=1 instance and one ALU_LAT=3 instance,
// each driving an XOR ALU model that ignores the opcode.
module tb_alu_share_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    always #5 clk = ~clk;

    // ALU_LAT = 1 instance
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a, req_b;
    logic [15:0]  req_op;
    logic [31:0]  alu_a, alu_b, alu_result;
    logic [3:0]   alu_op;
    logic         rsp_valid, rsp_ready, rsp_zero, busy;
    logic [31:0]  rsp_result;
    logic [1:0]   rsp_id;

    // ALU_LAT = 3 instance
    logic [3:0]   req_valid3;
    logic [3:0]   req_ready3;
    logic [127:0] req_a3, req_b3;
    logic [15:0]  req_op3;
    logic [31:0]  alu_a3, alu_b3, alu_result3;
    logic [3:0]   alu_op3;
    logic         rsp_valid3, rsp_ready3, rsp_zero3, busy3;
    logic [31:0]  rsp_result3;
    logic [1:0]   rsp_id3;
    logic [31:0]  pipe0, pipe1;

    int tests = 0;
    int fails = 0;

    alu_share_arbiter #(.NUM_REQ(4), .DATA_W(32), .OP_W(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_id(rsp_id), .busy(busy)
    );

    alu_share_arbiter #(.NUM_REQ(4), .DATA_W(32), .OP_W(4), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_result(alu_result3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
        .rsp_zero(rsp_zero3), .rsp_id(rsp_id3), .busy(busy3)
    );

    // XOR ALU models timed so the result is valid at the capture edge ALU_LAT cycles after accept.
    assign alu_result = alu_a ^ alu_b;

    always_ff @(posedge clk) begin
        pipe0 <= alu_a3 ^ alu_b3;
        pipe1 <= pipe0;
    end
    assign alu_result3 = pipe1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_res [4];

    initial begin
        exp_res[0] = 32'hAF; exp_res[1] = 32'hAE; exp_res[2] = 32'hAD; exp_res[3] = 32'hAC;

        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_op3 = '0; rsp_ready3 = 1'b0;
        tick; tick;

        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_op", 32'(alu_op), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_result", rsp_result, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;

        // 1: single op from requester 1
        req_a[32 +: 32] = 32'h0000_00F0;
        req_b[32 +: 32] = 32'h0000_000F;
        req_op[4 +: 4]  = 4'h5;
        req_valid = 4'b0010;
        #1;
        check("t1_ready", 32'(req_ready), 32'b0010);
        tick;
        req_valid = 4'b0000;
        check("t1_alu_op", 32'(alu_op), 32'h5);
        check("t1_alu_a", alu_a, 32'h0000_00F0);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_ready_wait", 32'(req_ready), 32'h0);
        check("t1_no_rsp_yet", 32'(rsp_valid), 32'h0);
        tick;
        check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1_rsp_result", rsp_result, 32'h0000_00FF);
        check("t1_rsp_id", 32'(rsp_id), 32'h1);
        check("t1_rsp_zero", 32'(rsp_zero), 32'h0);
        rsp_ready = 1'b1;
        tick;
        check("t1_rsp_done", 32'(rsp_valid), 32'h0);
        check("t1_idle", 32'(busy), 32'h0);

        // 2: all requesters valid, round-robin from reset
        rst = 1'b1; #1; rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'hA0 + 32'(i);
            req_b[i*32 +: 32] = 32'h0F;
            req_op[i*4 +: 4]  = 4'(i);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t2_ready", 32'(req_ready), 32'(1 << (k % 4)));
            tick;
            check("t2_alu_op", 32'(alu_op), 32'(k % 4));
            check("t2_ready_wait", 32'(req_ready), 32'h0);
            tick;
            check("t2_rsp_valid", 32'(rsp_valid), 32'h1);
            check("t2_rsp_id", 32'(rsp_id), 32'(k % 4));
            check("t2_rsp_result", rsp_result, exp_res[k % 4]);
            tick;
            check("t2_rsp_done", 32'(rsp_valid), 32'h0);
        end

        // 3: back-pressure on the response channel with req0 pending
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        check("t3_ready", 32'(req_ready), 32'b0001);
        tick; tick;
        for (int j = 0; j < 5; j++) begin
            check("t3_hold_valid", 32'(rsp_valid), 32'h1);
            check("t3_hold_result", rsp_result, 32'hAF);
            check("t3_hold_id", 32'(rsp_id), 32'h0);
            check("t3_hold_ready", 32'(req_ready), 32'h0);
            check("t3_hold_busy", 32'(busy), 32'h1);
            tick;
        end
        rsp_ready = 1'b1;
        req_a[0 +: 32] = 32'h55;
        tick;
        check("t3_after_hs_valid", 32'(rsp_valid), 32'h0);
        check("t3_after_hs_busy", 32'(busy), 32'h0);
        check("t3_after_hs_ready", 32'(req_ready), 32'b0001);
        tick;
        req_valid = 4'b0000;
        check("t3_reaccept_busy", 32'(busy), 32'h1);
        check("t3_reaccept_alu_a", alu_a, 32'h55);
        tick;
        check("t3_reaccept_rsp", rsp_result, 32'h5A);
        tick;

        // 4: zero result
        req_a[96 +: 32] = 32'hFFFF_FFFF;
        req_b[96 +: 32] = 32'hFFFF_FFFF;
        req_valid = 4'b1000;
        #1;
        check("t4_ready", 32'(req_ready), 32'b1000);
        tick;
        req_valid = 4'b0000;
        tick;
        check("t4_rsp_result", rsp_result, 32'h0);
        check("t4_rsp_zero", 32'(rsp_zero), 32'h1);
        check("t4_rsp_id", 32'(rsp_id), 32'h3);
        tick;

        // 5: reset during WAIT drops the op and restores the grant pointer
        req_a[64 +: 32] = 32'h1234;
        req_b[64 +: 32] = 32'h0;
        req_valid = 4'b0100;
        tick;
        check("t5_busy_wait", 32'(busy), 32'h1);
        check("t5_alu_a", alu_a, 32'h1234);
        rst = 1'b1;
        #1;
        check("t5_rst_alu_a", alu_a, 32'h0);
        check("t5_rst_alu_op", 32'(alu_op), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("t5_rst_rsp_result", rsp_result, 32'h0);
        check("t5_rst_rsp_id", 32'(rsp_id), 32'h0);
        check("t5_rst_ready", 32'(req_ready), 32'h0);
        req_valid = 4'b0000;
        tick;
        rst = 1'b0;
        tick; tick;
        check("t5_no_rsp", 32'(rsp_valid), 32'h0);
        req_valid = 4'b0101;
        #1;
        check("t5_first_grant", 32'(req_ready), 32'b0001);
        tick;
        req_valid = 4'b0100;
        check("t5_alu_a_req0", alu_a, 32'h55);
        tick;
        check("t5_rsp_id0", 32'(rsp_id), 32'h0);
        tick;
        check("t5_second_grant", 32'(req_ready), 32'b0100);
        tick;
        req_valid = 4'b0000;
        tick;
        check("t5_rsp_id2", 32'(rsp_id), 32'h2);
        check("t5_rsp_result2", rsp_result, 32'h1234);
        tick;

        // 6: ALU_LAT = 3 latency
        req_a3[96 +: 32] = 32'h1234_5678;
        req_b3[96 +: 32] = 32'h0F0F_0F0F;
        req_op3[12 +: 4] = 4'h9;
        rsp_ready3 = 1'b1;
        req_valid3 = 4'b1000;
        #1;
        check("t6_ready", 32'(req_ready3), 32'b1000);
        tick;
        req_valid3 = 4'b0000;
        check("t6_busy", 32'(busy3), 32'h1);
        check("t6_alu_op", 32'(alu_op3), 32'h9);
        tick;
        check("t6_no_rsp_t2", 32'(rsp_valid3), 32'h0);
        tick;
        check("t6_no_rsp_t3", 32'(rsp_valid3), 32'h0);
        tick;
        check("t6_rsp_valid", 32'(rsp_valid3), 32'h1);
        check("t6_rsp_result", rsp_result3, 32'h1D3B_5977);
        check("t6_rsp_id", 32'(rsp_id3), 32'h3);
        check("t6_rsp_zero", 32'(rsp_zero3), 32'h0);
        tick;
        check("t6_done", 32'(rsp_valid3), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
